// File: rtl/sys_bridge_pkg.sv
// Shared definitions for the sys_bridge slice: local register map, widths and the
// interrupt priority encoder.
package sys_bridge_pkg;

  localparam int unsigned HWINT_W    = 6;
  localparam int unsigned DEV_STRIDE = 16;

  typedef enum logic [1:0] {
    RegImask  = 2'd0,
    RegIpend  = 2'd1,
    RegIsrc   = 2'd2,
    RegErrcnt = 2'd3
  } loc_reg_e;

  // Returns index+1 of the lowest set bit, 0 when no bit is set.
  function automatic logic [2:0] prio_enc(input logic [HWINT_W-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = HWINT_W - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sys_bridge_if.sv
// CPU data port and device-side bus of sys_bridge; slave is the bridge view, master the
// view of whatever drives the CPU and device sides.
interface sys_bridge_if #(
  parameter int unsigned NUM_DEV = 2
);
  logic [31:0]           PrAddr;
  logic [31:0]           PrWD;
  logic                  PrWe;
  logic                  PrRe;
  logic [31:0]           PrRD;
  logic [31:0]           DevAddr;
  logic [31:0]           DevWD;
  logic [NUM_DEV-1:0]    DevWe;
  logic [32*NUM_DEV-1:0] DevRD;
  logic [NUM_DEV-1:0]    DevInt;
  logic                  IntAck;
  logic [5:0]            HWInt;
  logic                  BusErr;

  modport slave (
    input  PrAddr, PrWD, PrWe, PrRe, DevRD, DevInt, IntAck,
    output PrRD, DevAddr, DevWD, DevWe, HWInt, BusErr
  );

  modport master (
    output PrAddr, PrWD, PrWe, PrRe, DevRD, DevInt, IntAck,
    input  PrRD, DevAddr, DevWD, DevWe, HWInt, BusErr
  );
endinterface

// File: rtl/sys_bridge_irq.sv
// Interrupt aggregation: edge latch, IPEND/IMASK, ISRC encoder and IntAck clear.
// SYS_BRIDGE_LEVEL_EN makes IPEND follow the live DevInt level instead.
module sys_bridge_irq
  import sys_bridge_pkg::*;
#(
  parameter int unsigned NumDev = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumDev-1:0]  dev_int_i,
  input  logic               imask_we_i,
  input  logic               ipend_w1c_i,
  input  logic [NumDev-1:0]  wdata_i,
  input  logic               int_ack_i,
  output logic [NumDev-1:0]  imask_o,
  output logic [NumDev-1:0]  ipend_o,
  output logic [2:0]         isrc_o,
  output logic [HWINT_W-1:0] hwint_o
);

  logic [NumDev-1:0] imask_q, imask_d;

  always_comb begin
    imask_d = imask_we_i ? wdata_i : imask_q;
  end

`ifdef SYS_BRIDGE_LEVEL_EN
  logic unused_clr;
  assign unused_clr = ipend_w1c_i ^ int_ack_i;
  assign ipend_o    = dev_int_i;
`else
  logic [NumDev-1:0] ipend_q, ipend_d;
  logic [NumDev-1:0] dint_q;
  logic [NumDev-1:0] clr;

  // A new edge wins over any clear of the same bit.
  always_comb begin
    clr = ipend_w1c_i ? wdata_i : '0;
    for (int i = 0; i < NumDev; i++) begin
      if (int_ack_i && (isrc_o == 3'(i + 1))) clr[i] = 1'b1;
    end
    ipend_d = (ipend_q & ~clr) | (dev_int_i & ~dint_q);
  end

  // dint_q keeps tracking during reset so a level held across reset is not an edge.
  always_ff @(posedge clk_i) begin
    dint_q <= dev_int_i;
    if (rst_i) ipend_q <= '0;
    else       ipend_q <= ipend_d;
  end

  assign ipend_o = ipend_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) imask_q <= '0;
    else       imask_q <= imask_d;
  end

  always_comb begin
    hwint_o             = '0;
    hwint_o[NumDev-1:0] = ipend_o & imask_q;
  end

  assign isrc_o  = prio_enc(hwint_o);
  assign imask_o = imask_q;

endmodule

// File: rtl/sys_bridge.sv
// Top of the CPU-to-peripheral bridge: address decode, read mux, local register bank
// and bus-error counter. Optional level-mode interrupts via SYS_BRIDGE_LEVEL_EN.
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV  = 2,
  parameter logic [31:0] DEV_BASE = 32'h0000_7f00,
  parameter int unsigned ERR_W    = 16
) (
  input logic        clk,
  input logic        reset,
  sys_bridge_if.slave bus_io
);

  logic [NUM_DEV-1:0] dev_hit;
  logic               loc_hit;
  logic               acc;
  logic               err_hit;
  logic               loc_we;
  loc_reg_e           loc_sel;
  logic [NUM_DEV-1:0] imask, ipend;
  logic [2:0]         isrc;
  logic [31:0]        loc_rd;
  logic               buserr_q, buserr_d;
  logic [ERR_W-1:0]   errcnt_q, errcnt_d;

  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_hit[i] = bus_io.PrAddr[31:4] == 28'((DEV_BASE + DEV_STRIDE * i) >> 4);
    end
    loc_hit = bus_io.PrAddr[31:4] == 28'((DEV_BASE + DEV_STRIDE * NUM_DEV) >> 4);
  end

  assign acc     = bus_io.PrWe | bus_io.PrRe;
  assign err_hit = acc & ~(loc_hit | (|dev_hit));
  assign loc_we  = bus_io.PrWe & loc_hit;
  assign loc_sel = loc_reg_e'(bus_io.PrAddr[3:2]);

  assign bus_io.DevAddr = bus_io.PrAddr;
  assign bus_io.DevWD   = bus_io.PrWD;
  assign bus_io.DevWe   = bus_io.PrWe ? dev_hit : '0;

  sys_bridge_irq #(
    .NumDev(NUM_DEV)
  ) u_irq (
    .clk_i      (clk),
    .rst_i      (reset),
    .dev_int_i  (bus_io.DevInt),
    .imask_we_i (loc_we && (loc_sel == RegImask)),
    .ipend_w1c_i(loc_we && (loc_sel == RegIpend)),
    .wdata_i    (bus_io.PrWD[NUM_DEV-1:0]),
    .int_ack_i  (bus_io.IntAck),
    .imask_o    (imask),
    .ipend_o    (ipend),
    .isrc_o     (isrc),
    .hwint_o    (bus_io.HWInt)
  );

  always_comb begin
    loc_rd = '0;
    unique case (loc_sel)
      RegImask:  loc_rd = 32'(imask);
      RegIpend:  loc_rd = 32'(ipend);
      RegIsrc:   loc_rd = 32'(isrc);
      RegErrcnt: loc_rd = 32'(errcnt_q);
      default:   loc_rd = '0;
    endcase
  end

  // Device hits are one-hot, so OR-ing the gated slices forms the mux.
  always_comb begin
    bus_io.PrRD = loc_hit ? loc_rd : 32'h0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_hit[i]) bus_io.PrRD = bus_io.PrRD | bus_io.DevRD[32*i +: 32];
    end
  end

  always_comb begin
    buserr_d = err_hit;
    errcnt_d = errcnt_q;
    if (loc_we && (loc_sel == RegErrcnt)) begin
      errcnt_d = '0;
    end else if (err_hit && (errcnt_q != {ERR_W{1'b1}})) begin
      errcnt_d = errcnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buserr_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      buserr_q <= buserr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign bus_io.BusErr = buserr_q;

endmodule

// File: tb/tb_sys_bridge.sv
// Directed scoreboard bench for sys_bridge in its default (edge-latched) build.
module tb_sys_bridge;

  localparam int SelRd = 0;
  localparam int SelWe = 1;
  localparam int SelHw = 2;
  localparam int SelBe = 3;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];

  sys_bridge_if #(.NUM_DEV(2)) bus ();

  sys_bridge #(
    .NUM_DEV (2),
    .DEV_BASE(32'h0000_7f00),
    .ERR_W   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SelRd:   return bus.PrRD;
      SelWe:   return 32'(bus.DevWe);
      SelHw:   return 32'(bus.HWInt);
      default: return 32'(bus.BusErr);
    endcase
  endfunction

  // Monitor: retire every expectation whose cycle has come.
  always @(negedge clk) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due <= cyc) begin
        checks++;
        if (sb[k].due < cyc) begin
          failures++;
          $display("FAIL %s: stale expectation due %0d at cycle %0d", sb[k].name, sb[k].due,
                   cyc);
        end else if (sample(sb[k].sel) !== sb[k].exp) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", sb[k].name,
                   sample(sb[k].sel), sb[k].exp, cyc);
        end
        sb.delete(k);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic re);
    bus.PrAddr = a;
    bus.PrWD   = d;
    bus.PrWe   = we;
    bus.PrRe   = re;
  endtask

  task automatic idle();
    acc(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string n, input int sel, input logic [31:0] v, input int lat);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.exp  = v;
    e.due  = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] v);
    acc(a, 32'h0, 1'b0, 1'b1);
    chk(n, SelRd, v, 0);
    step();
    idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    acc(a, d, 1'b1, 1'b0);
    step();
    idle();
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.DevRD  = {32'h0000_abcd, 32'h0000_1234};
    bus.DevInt = 2'b00;
    bus.IntAck = 1'b0;
    idle();
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_hwint", SelHw, 32'h0, 0);
    chk("rst_buserr", SelBe, 32'h0, 0);
    chk("rst_devwe", SelWe, 32'h0, 0);
    rd_chk("rst_imask", 32'h7f20, 32'h0);
    rd_chk("rst_errcnt", 32'h7f2c, 32'h0);

    // Decode and read mux
    acc(32'h7f04, 32'h5, 1'b1, 1'b0);
    chk("store_devwe", SelWe, 32'h1, 0);
    chk("store_noerr", SelBe, 32'h0, 1);
    step();
    idle();
    chk("store_devwe_off", SelWe, 32'h0, 0);
    step();
    rd_chk("load_dev1", 32'h7f14, 32'h0000_abcd);
    rd_chk("load_dev0", 32'h7f08, 32'h0000_1234);
    acc(32'h7f18, 32'h9, 1'b1, 1'b1);
    chk("store_load_we", SelWe, 32'h2, 0);
    chk("store_load_rd", SelRd, 32'h0000_abcd, 0);
    step();
    idle();

    // Edge latch, held level sets once
    wr(32'h7f20, 32'h3);
    bus.DevInt = 2'b10;
    chk("rise_hw_same", SelHw, 32'h0, 0);
    chk("rise_hw_next", SelHw, 32'h2, 1);
    step();
    repeat (9) step();
    rd_chk("hold_ipend", 32'h7f24, 32'h2);
    rd_chk("hold_isrc", 32'h7f28, 32'h2);
    wr(32'h7f24, 32'h2);
    rd_chk("hold_once", 32'h7f24, 32'h0);
    chk("hold_once_hw", SelHw, 32'h0, 0);
    bus.DevInt = 2'b00;
    step();

    // Masked pending, then unmask
    wr(32'h7f20, 32'h1);
    bus.DevInt = 2'b10;
    step();
    chk("masked_hw", SelHw, 32'h0, 0);
    rd_chk("masked_ipend", 32'h7f24, 32'h2);
    acc(32'h7f20, 32'h3, 1'b1, 1'b0);
    chk("unmask_hw", SelHw, 32'h2, 1);
    step();
    idle();
    step();

    // IntAck clears the ISRC bit; set beats W1C clear
    bus.DevInt = 2'b01;
    step();
    rd_chk("two_ipend", 32'h7f24, 32'h3);
    rd_chk("two_isrc", 32'h7f28, 32'h1);
    chk("two_hw", SelHw, 32'h3, 0);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    rd_chk("ack_ipend", 32'h7f24, 32'h2);
    rd_chk("ack_isrc", 32'h7f28, 32'h2);
    bus.DevInt = 2'b11;
    wr(32'h7f24, 32'h2);
    rd_chk("setwins_ipend", 32'h7f24, 32'h2);
    wr(32'h7f24, 32'h3);
    rd_chk("w1c_both", 32'h7f24, 32'h0);
    rd_chk("isrc_none", 32'h7f28, 32'h0);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    rd_chk("ack_noop", 32'h7f24, 32'h0);

    // Unmapped accesses
    for (int n = 0; n < 3; n++) begin
      acc(32'h8000, 32'h0, 1'b0, 1'b1);
      chk("err_rd", SelRd, 32'h0, 0);
      chk("err_devwe", SelWe, 32'h0, 0);
      chk("err_pulse", SelBe, 32'h1, 1);
      step();
    end
    idle();
    chk("err_drop", SelBe, 32'h0, 1);
    step();
    rd_chk("errcnt3", 32'h7f2c, 32'h3);
    wr(32'h7f2c, 32'h0);
    rd_chk("errcnt_clr", 32'h7f2c, 32'h0);
    acc(32'h7f30, 32'hffff_ffff, 1'b1, 1'b0);
    chk("err_wr_devwe", SelWe, 32'h0, 0);
    chk("err_wr_pulse", SelBe, 32'h1, 1);
    step();
    idle();
    step();
    rd_chk("errcnt1", 32'h7f2c, 32'h1);

    // Reset mid-operation
    bus.DevInt = 2'b00;
    step();
    bus.DevInt = 2'b11;
    step();
    chk("pre_rst_hw", SelHw, 32'h3, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_rst_hw", SelHw, 32'h0, 0);
    rd_chk("post_rst_ipend", 32'h7f24, 32'h0);
    rd_chk("post_rst_imask", 32'h7f20, 32'h0);
    rd_chk("post_rst_errcnt", 32'h7f2c, 32'h0);
    wr(32'h7f20, 32'h3);
    rd_chk("held_no_edge", 32'h7f24, 32'h0);
    chk("held_no_edge_hw", SelHw, 32'h0, 0);
    step();

    repeat (3) step();
    while (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: never checked, expected 0x%08h", sb[0].name, sb[0].exp);
      sb.delete(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
